// File: rtl/collector_arbiter.sv
// collector_arbiter: round-robin arbiter that funnels numPorts sources into one collector channel.
// Define ARB_STATS_EN to add per-source saturating grant counters readable via StatSel/StatCount.
module collector_arbiter #(
    parameter int numPorts  = 4,
    parameter int idxWidth  = 2,
    parameter int dataWidth = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [numPorts*dataWidth-1:0] PacketIn,
    input  logic [numPorts-1:0]           ReqUpStr,
    output logic [numPorts-1:0]           GntUpStr,
    output logic [numPorts-1:0]           UpStrFull,
    output logic [dataWidth-1:0]          PacketOut,
    output logic                          ReqDnStr,
    input  logic                          GntDnStr,
    input  logic                          DnStrFull
`ifdef ARB_STATS_EN
    ,
    input  logic [idxWidth-1:0]           StatSel,
    output logic [15:0]                   StatCount
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, GRANT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [idxWidth-1:0]  rr_ptr_q, rr_ptr_d, winner_q, winner_d, pick, idx;
    logic [dataWidth-1:0] packet_q, packet_d;
    logic [numPorts-1:0]  gnt_q, gnt_d, full_q;
    logic                 req_q, req_d;

    // Scan downward so the requester closest to rr_ptr_q is the last (winning) assignment.
    always_comb begin
        pick = rr_ptr_q;
        idx  = '0;
        for (int k = numPorts - 1; k >= 0; k--) begin
            idx = idxWidth'((int'(rr_ptr_q) + k) % numPorts);
            if (ReqUpStr[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        packet_d = packet_q;
        req_d    = req_q;
        gnt_d    = '0;
        case (state_q)
            IDLE: if (|ReqUpStr && !DnStrFull) begin
                winner_d = pick;
                packet_d = PacketIn[pick*dataWidth +: dataWidth];
                req_d    = 1'b1;
                state_d  = WAIT_GNT;
            end
            WAIT_GNT: if (GntDnStr) begin
                req_d    = 1'b0;
                gnt_d    = {{(numPorts-1){1'b0}}, 1'b1} << winner_q;
                rr_ptr_d = (int'(winner_q) == numPorts - 1) ? '0 : winner_q + 1'b1;
                state_d  = GRANT;
            end
            GRANT:   state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            packet_q <= '0;
            req_q    <= 1'b0;
            gnt_q    <= '0;
            full_q   <= '1;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            packet_q <= packet_d;
            req_q    <= req_d;
            gnt_q    <= gnt_d;
            full_q   <= {numPorts{DnStrFull}};
        end
    end

    assign GntUpStr  = gnt_q;
    assign UpStrFull = full_q;
    assign PacketOut = packet_q;
    assign ReqDnStr  = req_q;

`ifdef ARB_STATS_EN
    logic [15:0] cnt_q [numPorts];
    logic [15:0] cnt_d [numPorts];
    logic [15:0] stat_q, stat_d;

    always_comb begin
        for (int i = 0; i < numPorts; i++)
            cnt_d[i] = (state_q == WAIT_GNT && GntDnStr && int'(winner_q) == i && cnt_q[i] != 16'hFFFF)
                       ? cnt_q[i] + 16'd1 : cnt_q[i];
        stat_d = (int'(StatSel) < numPorts) ? cnt_q[StatSel] : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < numPorts; i++) cnt_q[i] <= '0;
            stat_q <= '0;
        end else begin
            for (int i = 0; i < numPorts; i++) cnt_q[i] <= cnt_d[i];
            stat_q <= stat_d;
        end
    end

    assign StatCount = stat_q;
`endif
endmodule
